// File: rtl/cap_touch_pkg.sv
// -----------------------------------------------------------------------------
// cap_touch_pkg
// Shared definitions for the capacitive touch scanner:
//   - cap_state_e : scan FSM states (IDLE, CHARGE, MEASURE, EVAL)
//   - NUM_PADS    : number of pads fitted on the board
//   - DEF_*       : default values for the scanner parameters
// -----------------------------------------------------------------------------
package cap_touch_pkg;

   localparam int NUM_PADS          = 9;

   localparam int DEF_CNT_W         = 12;
   localparam int DEF_CHARGE_CYCLES = 64;
   localparam int DEF_TIMEOUT       = 2000;
   localparam int DEF_THRESHOLD     = 400;
   localparam int DEF_DEBOUNCE      = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHARGE  = 2'd1,
      MEASURE = 2'd2,
      EVAL    = 2'd3
   } cap_state_e;

endpackage

// File: rtl/cap_pad_channel.sv
// -----------------------------------------------------------------------------
// cap_pad_channel
// One pad's worth of the scanner: input synchronizer, discharge-time capture,
// debounce and sticky press event.
//
// Ports:
//   clock, reset   : system clock, asynchronous active-high reset
//   sense_i        : raw asynchronous pad level
//   clear_i        : drop the previous capture (held during CHARGE)
//   measure_i      : scanner is in MEASURE; capture is allowed
//   cnt_i          : shared measure counter
//   commit_i       : EVAL cycle of a scan that was not aborted
//   events_clr_i   : clear the sticky press event
//   captured_o     : this pad has captured during the current scan
//   count_o        : captured count, or TIMEOUT when nothing was captured
//   touched_o      : debounced touch state
//   press_o        : sticky rising-edge flag of touched_o
// -----------------------------------------------------------------------------
module cap_pad_channel
   import cap_touch_pkg::*;
#(
   parameter int CNT_W     = DEF_CNT_W,
   parameter int TIMEOUT   = DEF_TIMEOUT,
   parameter int THRESHOLD = DEF_THRESHOLD,
   parameter int DEBOUNCE  = DEF_DEBOUNCE
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sense_i,
   input  logic             clear_i,
   input  logic             measure_i,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic             commit_i,
   input  logic             events_clr_i,
   output logic             captured_o,
   output logic [CNT_W-1:0] count_o,
   output logic             touched_o,
   output logic             press_o
);

   localparam int DB_W = $clog2(DEBOUNCE + 1);

   logic             sync1_q, sync2_q;
   logic             captured_q;
   logic [CNT_W-1:0] cap_q;
   logic [DB_W-1:0]  db_q, db_d;
   logic             touched_q, touched_d;
   logic             press_q, press_d;
   logic             raw;

   // Two-flop synchronizer; sync2_q is the only copy of the pad used downstream.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sense_i;
         sync2_q <= sync1_q;
      end
   end

   // First low cycle in MEASURE wins; later cycles cannot overwrite it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         captured_q <= 1'b0;
         cap_q      <= '0;
      end else if (clear_i) begin
         captured_q <= 1'b0;
         cap_q      <= '0;
      end else if (measure_i && !captured_q && !sync2_q) begin
         captured_q <= 1'b1;
         cap_q      <= cnt_i;
      end
   end

   // A pad that never discharged reads as the full timeout.
   assign count_o    = captured_q ? cap_q : CNT_W'(TIMEOUT);
   assign captured_o = captured_q;
   assign raw        = (count_o >= CNT_W'(THRESHOLD));

   always_comb begin
      db_d      = db_q;
      touched_d = touched_q;
      if (commit_i) begin
         if (raw != touched_q) begin
            if (db_q == DB_W'(DEBOUNCE - 1)) begin
               touched_d = ~touched_q;
               db_d      = '0;
            end else begin
               db_d = db_q + DB_W'(1);
            end
         end else begin
            db_d = '0;
         end
      end
   end

   // A new press has priority over a clear landing on the same edge.
   always_comb begin
      press_d = press_q;
      if (touched_d && !touched_q) begin
         press_d = 1'b1;
      end else if (events_clr_i) begin
         press_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         db_q      <= '0;
         touched_q <= 1'b0;
         press_q   <= 1'b0;
      end else begin
         db_q      <= db_d;
         touched_q <= touched_d;
         press_q   <= press_d;
      end
   end

   assign touched_o = touched_q;
   assign press_o   = press_q;

endmodule

// File: rtl/cap_touch_scanner.sv
// -----------------------------------------------------------------------------
// cap_touch_scanner
// Scans NUM_PADS capacitive pads: charges them through a shared drive pin,
// times each pad's discharge, debounces the raw touches across scans and
// keeps sticky press events for software to poll.
//
// Ports:
//   clock, reset           : system clock, asynchronous active-high reset
//   enable                 : scanning permitted; dropping it aborts a scan
//   capacitive_sensors_in  : raw asynchronous pad levels
//   capacitive_sensors_out : shared charge/drive pin
//   touched                : debounced touch state
//   press_events           : sticky rising-edge flags of touched
//   events_clr             : one-cycle pulse clearing all press_events
//   scan_done              : one-cycle pulse when a scan's results commit
//   fsm_state_o            : current scan FSM state (observability)
//   debug_counts           : last committed count per pad, pad i at
//                            [i*CNT_W +: CNT_W] (only with CAP_TOUCH_DEBUG_EN)
//
// Build option: define CAP_TOUCH_DEBUG_EN to add debug_counts.
//
// Handshake: scan_done is a single-cycle strobe with no back-pressure; it is
// high in the cycle after EVAL, the same cycle touched/press_events first show
// the new results. events_clr is sampled on every edge; a press set on that
// same edge still lands.
// -----------------------------------------------------------------------------
module cap_touch_scanner #(
   parameter int NUM_PADS      = cap_touch_pkg::NUM_PADS,
   parameter int CNT_W         = cap_touch_pkg::DEF_CNT_W,
   parameter int CHARGE_CYCLES = cap_touch_pkg::DEF_CHARGE_CYCLES,
   parameter int TIMEOUT       = cap_touch_pkg::DEF_TIMEOUT,
   parameter int THRESHOLD     = cap_touch_pkg::DEF_THRESHOLD,
   parameter int DEBOUNCE      = cap_touch_pkg::DEF_DEBOUNCE
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [NUM_PADS-1:0]      capacitive_sensors_in,
   output logic                     capacitive_sensors_out,
   output logic [NUM_PADS-1:0]      touched,
   output logic [NUM_PADS-1:0]      press_events,
   input  logic                     events_clr,
   output logic                     scan_done,
   output cap_touch_pkg::cap_state_e fsm_state_o
`ifdef CAP_TOUCH_DEBUG_EN
   ,
   output logic [NUM_PADS*CNT_W-1:0] debug_counts
`endif
);

   import cap_touch_pkg::*;

   localparam int CH_W = $clog2(CHARGE_CYCLES + 1);

   cap_state_e       state_q, state_d;
   logic [CH_W-1:0]  charge_cnt_q, charge_cnt_d;
   logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
   logic             drive_q;
   logic             scan_done_q;
   logic             eval_commit;
   logic             all_captured;

   logic [NUM_PADS-1:0] captured;
   logic [CNT_W-1:0]    pad_count [NUM_PADS];

   assign all_captured = &captured;
   // EVAL with enable still high is the only point a scan's results commit.
   assign eval_commit  = (state_q == EVAL) && enable;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (enable) state_d = CHARGE;
         end
         CHARGE: begin
            if (!enable) state_d = IDLE;
            else if (charge_cnt_q == CH_W'(CHARGE_CYCLES - 1)) state_d = MEASURE;
         end
         MEASURE: begin
            // all_captured reflects flags registered last cycle, so the early
            // exit lands one cycle after the final capture.
            if (!enable) state_d = IDLE;
            else if (all_captured || meas_cnt_q == CNT_W'(TIMEOUT - 1)) state_d = EVAL;
         end
         EVAL: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      charge_cnt_d = '0;
      meas_cnt_d   = '0;
      if (state_q == CHARGE) begin
         charge_cnt_d = charge_cnt_q + CH_W'(1);
      end
      if (state_q == MEASURE) begin
         meas_cnt_d = (meas_cnt_q == CNT_W'(TIMEOUT)) ? meas_cnt_q : meas_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         charge_cnt_q <= '0;
         meas_cnt_q   <= '0;
         drive_q      <= 1'b0;
         scan_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         charge_cnt_q <= charge_cnt_d;
         meas_cnt_q   <= meas_cnt_d;
         // Registered so the pad drive never glitches on state decode.
         drive_q      <= (state_d == CHARGE);
         scan_done_q  <= eval_commit;
      end
   end

   for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
      cap_pad_channel #(
         .CNT_W     (CNT_W),
         .TIMEOUT   (TIMEOUT),
         .THRESHOLD (THRESHOLD),
         .DEBOUNCE  (DEBOUNCE)
      ) u_ch (
         .clock        (clock),
         .reset        (reset),
         .sense_i      (capacitive_sensors_in[i]),
         .clear_i      (state_q == CHARGE),
         .measure_i    (state_q == MEASURE),
         .cnt_i        (meas_cnt_q),
         .commit_i     (eval_commit),
         .events_clr_i (events_clr),
         .captured_o   (captured[i]),
         .count_o      (pad_count[i]),
         .touched_o    (touched[i]),
         .press_o      (press_events[i])
      );
   end

`ifdef CAP_TOUCH_DEBUG_EN
   logic [NUM_PADS*CNT_W-1:0] dbg_counts_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dbg_counts_q <= '0;
      end else if (eval_commit) begin
         for (int i = 0; i < NUM_PADS; i++) begin
            dbg_counts_q[i*CNT_W +: CNT_W] <= pad_count[i];
         end
      end
   end

   assign debug_counts = dbg_counts_q;
`endif

   assign capacitive_sensors_out = drive_q;
   assign scan_done              = scan_done_q;
   assign fsm_state_o            = state_q;

endmodule

// File: doc/cap_touch_scanner.md
# cap_touch_scanner

- Front end between the nine capacitive pads and the processor's memory-mapped input path.
- Each scan charges all pads through the shared drive pin, then times how long each pad takes to discharge.
- A pad with a long discharge is a raw touch; raw touches are debounced across scans.
- Outputs are a stable touched vector plus sticky press events that the game software polls and clears.

## Interface
- NUM_PADS, 9, number of pads / sensor inputs
- CNT_W, 12, width of the discharge counter
- CHARGE_CYCLES, 64, cycles the drive pin is held high per scan
- TIMEOUT, 2000, maximum measure cycles; also the saturation count (must be < 2^CNT_W)
- THRESHOLD, 400, count >= THRESHOLD means raw touch
- DEBOUNCE, 3, consecutive disagreeing scans needed to flip a pad's debounced state (>= 1)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  scanning permitted
- capacitive_sensors_in  in  NUM_PADS  raw asynchronous pad levels
- capacitive_sensors_out  out  1  shared charge/drive pin
- touched  out  NUM_PADS  debounced touch state
- press_events  out  NUM_PADS  sticky rising-edge flags of touched
- events_clr  in  1  one-cycle pulse; clears all press_events
- scan_done  out  1  one-cycle pulse when a scan's results are committed

## Operation
- Each sensor input passes through a 2-flop synchronizer before any use.
- FSM states: IDLE, CHARGE, MEASURE, EVAL.
- IDLE:
  - capacitive_sensors_out = 0.
  - Moves to CHARGE on the next cycle when enable = 1.
- CHARGE:
  - capacitive_sensors_out = 1 for exactly CHARGE_CYCLES cycles, then moves to MEASURE.
  - The measure counter is cleared to 0.
- MEASURE:
  - capacitive_sensors_out = 0; the counter increments once per cycle.
  - Each pad latches the counter value on the first cycle its synchronized input is 0; that capture is final for the scan.
  - A pad already low on the first MEASURE cycle captures 0.
  - Leaves after TIMEOUT cycles, or early on the cycle after every pad has captured.
  - Any pad not yet captured is assigned TIMEOUT.
- EVAL (one cycle):
  - raw[i] = (count[i] >= THRESHOLD).
  - Debounce update runs; scan_done = 1; returns to IDLE.
- Debounce:
  - Per-pad counter of consecutive scans with raw != touched.
  - The counter resets to 0 on any agreeing scan.
  - When it reaches DEBOUNCE, touched flips and the counter resets.
- Press events:
  - press_events[i] sets when touched[i] goes 0 -> 1 and holds until events_clr.
  - If a set and events_clr occur in the same cycle, set wins.
  - Release (1 -> 0) produces no event.
- enable deasserted mid-scan:
  - Aborts at the next clock edge and returns to IDLE.
  - No debounce update, no scan_done; touched and press_events are held.

## Timing
- Reset values: capacitive_sensors_out = 0, touched = 0, press_events = 0, scan_done = 0; FSM in IDLE; all counters 0.
- Reset mid-scan forces the above immediately (asynchronous).
- Scan period with continuous enable: 1 (IDLE) + CHARGE_CYCLES + M + 1 (EVAL) cycles, where M = measure cycles (<= TIMEOUT).
- The captured count includes the 2-cycle synchronizer latency. No compensation is applied; THRESHOLD is tuned with that latency included.
- touched and press_events update on the clock edge that ends EVAL, coincident with the scan_done pulse.
- Minimum press-to-touched latency is DEBOUNCE scans.
- Counter arithmetic is unsigned and saturates at TIMEOUT; it never wraps.

## Configuration
- CAP_TOUCH_DEBUG_EN defined:
  - Adds output debug_counts [NUM_PADS*CNT_W-1:0], holding each pad's last committed count (pad i at bits [i*CNT_W +: CNT_W]).
  - Updated with scan_done; reset value 0.
- CAP_TOUCH_DEBUG_EN undefined: the port and its storage do not exist. All other behaviour is identical.

## Structure
- Package cap_touch_pkg holds:
  - the FSM state enum (IDLE, CHARGE, MEASURE, EVAL);
  - default parameter constants;
  - the NUM_PADS = 9 board constant.
- Sub-module cap_pad_channel, instanced NUM_PADS times, contains:
  - the synchronizer;
  - capture register and captured flag;
  - debounce counter, touched bit, and press-event bit.
- The top level holds the FSM, the shared counter, and the all-captured reduction.

## Test plan
All scenarios use CHARGE_CYCLES=4, TIMEOUT=32, THRESHOLD=10, DEBOUNCE=2.
- Idle pads: all inputs fall 3 cycles into MEASURE.
  - Required: counts stay below 10, touched = 0, press_events = 0.
  - Early exit: scan_done arrives well before TIMEOUT.
- Touch pad 4: input 4 held high through MEASURE, others fall early.
  - After scan 1: touched = 0.
  - After scan 2: touched = 9'h010 and press_events = 9'h010.
  - events_clr then gives press_events = 0 while touched stays 9'h010.
- Single-scan glitch: pad 0 touched for one scan only.
  - Required: touched[0] never sets; its debounce counter returns to 0.
- Simultaneous set and clear: events_clr pulsed on the same edge as pad 2's rising edge.
  - Required: press_events[2] = 1.
- Abort: enable dropped during MEASURE.
  - Required: FSM reaches IDLE next cycle, capacitive_sensors_out = 0, no scan_done, outputs unchanged.
  - Re-enable: the next scan starts in CHARGE.
- Asynchronous reset mid-CHARGE: asserted with pads touched.
  - Required: all outputs go to 0 before the next clock edge.
  - After release: scanning restarts from IDLE.
